// File: rtl/wb_stage_if.sv
// wb_stage_if: WB-side pipeline inputs and register-file write/forwarding outputs of wb_stage.
// Latency: none (bundle of wires); wbk_* are combinational, wbk_*_h/ld_code_err/wr_cnt registered.
// Backpressure: none; stall is an input from the pipeline controller, the stage never stalls upstream.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  // pipeline-register side (driven by MA stage / pipeline controller)
  logic             cmd_ld_wb;
  logic [2:0]       ld_code_wb;
  logic [4:0]       rd_adr_wb;
  logic [31:0]      rd_data_wb;
  logic             wbk_rd_reg_wb;
  logic [31:0]      ld_data_wb;
  logic             stall;
  logic             rst_pipe_wb;
  logic             cnt_clr;

  // register-file write port and forwarding hold copy
  logic             wbk_en;
  logic [4:0]       wbk_adr;
  logic [31:0]      wbk_data;
  logic             wbk_en_h;
  logic [4:0]       wbk_adr_h;
  logic [31:0]      wbk_data_h;
  logic             ld_code_err;
  logic [CNT_W-1:0] wr_cnt;

  // upstream / environment view
  modport master (
    output cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb, wbk_rd_reg_wb,
           ld_data_wb, stall, rst_pipe_wb, cnt_clr,
    input  wbk_en, wbk_adr, wbk_data, wbk_en_h, wbk_adr_h, wbk_data_h,
           ld_code_err, wr_cnt
  );

  // write-back stage view
  modport slave (
    input  cmd_ld_wb, ld_code_wb, rd_adr_wb, rd_data_wb, wbk_rd_reg_wb,
           ld_data_wb, stall, rst_pipe_wb, cnt_clr,
    output wbk_en, wbk_adr, wbk_data, wbk_en_h, wbk_adr_h, wbk_data_h,
           ld_code_err, wr_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: load extract/sign-extend, regfile write port, one-deep forwarding hold copy; optional
// write-retire counter under macro WB_PERF_CNT_EN. Latency: write port is combinational (0 cycles),
// hold copy / ld_code_err / wr_cnt one cycle. Backpressure: none; stall freezes the hold copy only.
module wb_stage #(
  parameter int CNT_W = 32   // must match the CNT_W of the connected wb_stage_if
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  wb
);

  // funct3 encodings of the supported loads
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  logic [1:0]  ld_ofs;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        ld_illegal;
  logic        ld_err_req;

  logic        wbk_en;
  logic [31:0] wbk_data;

  logic        wbk_en_h_q,   wbk_en_h_d;
  logic [4:0]  wbk_adr_h_q,  wbk_adr_h_d;
  logic [31:0] wbk_data_h_q, wbk_data_h_d;
  logic        ld_code_err_q, ld_code_err_d;

  // Select the addressed byte/half of the aligned load word and extend it per funct3.
  always_comb begin
    ld_ofs     = wb.rd_data_wb[1:0];
    ld_byte    = wb.ld_data_wb[7:0];
    ld_ext     = '0;
    ld_illegal = 1'b0;
    case (ld_ofs)
      2'd0:    ld_byte = wb.ld_data_wb[7:0];
      2'd1:    ld_byte = wb.ld_data_wb[15:8];
      2'd2:    ld_byte = wb.ld_data_wb[23:16];
      default: ld_byte = wb.ld_data_wb[31:24];
    endcase
    // halfwords are taken on the upper address bit only; ofs[0] is don't-care
    ld_half = ld_ofs[1] ? wb.ld_data_wb[31:16] : wb.ld_data_wb[15:0];
    case (wb.ld_code_wb)
      LD_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LD_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      LD_LW:   ld_ext = wb.ld_data_wb;
      LD_LBU:  ld_ext = {24'd0, ld_byte};
      LD_LHU:  ld_ext = {16'd0, ld_half};
      default: begin
        ld_ext     = '0;
        ld_illegal = 1'b1;
      end
    endcase
  end

  // Register-file write port: x0 is never written, flushes and illegal loads suppress the write.
  always_comb begin
    ld_err_req = wb.cmd_ld_wb & wb.wbk_rd_reg_wb & ld_illegal;
    wbk_en     = wb.wbk_rd_reg_wb & (wb.rd_adr_wb != 5'd0) & ~wb.rst_pipe_wb & ~ld_err_req;
    wbk_data   = wb.cmd_ld_wb ? ld_ext : wb.rd_data_wb;
  end

  assign wb.wbk_en   = wbk_en;
  assign wb.wbk_adr  = wb.rd_adr_wb;
  assign wb.wbk_data = wbk_data;

  // Hold-copy next state: flush clears only the valid bit; a write always refreshes the copy,
  // even under stall, so ID/EX can forward the newest value while the pipeline is frozen.
  always_comb begin
    wbk_en_h_d    = wbk_en_h_q;
    wbk_adr_h_d   = wbk_adr_h_q;
    wbk_data_h_d  = wbk_data_h_q;
    ld_code_err_d = ld_err_req;
    if (wb.rst_pipe_wb) begin
      wbk_en_h_d = 1'b0;
    end else if (!wb.stall || wbk_en) begin
      wbk_en_h_d   = wbk_en;
      wbk_adr_h_d  = wb.rd_adr_wb;
      wbk_data_h_d = wbk_data;
    end
  end

  // Hold-copy and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbk_en_h_q    <= 1'b0;
      wbk_adr_h_q   <= 5'd0;
      wbk_data_h_q  <= 32'd0;
      ld_code_err_q <= 1'b0;
    end else begin
      wbk_en_h_q    <= wbk_en_h_d;
      wbk_adr_h_q   <= wbk_adr_h_d;
      wbk_data_h_q  <= wbk_data_h_d;
      ld_code_err_q <= ld_code_err_d;
    end
  end

  assign wb.wbk_en_h    = wbk_en_h_q;
  assign wb.wbk_adr_h   = wbk_adr_h_q;
  assign wb.wbk_data_h  = wbk_data_h_q;
  assign wb.ld_code_err = ld_code_err_q;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Counter next state: clear beats increment; natural wrap at 2^CNT_W.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wb.cnt_clr) begin
      wr_cnt_d = '0;
    end else if (wbk_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  // Committed-write counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wb.wr_cnt = wr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = wb.cnt_clr;
  assign wb.wr_cnt      = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors for wb_stage with literal expectations plus a per-cycle model compare.
// Latency: model predicts the combinational port and the one-cycle registered outputs.
// Backpressure: stall/flush driven directly; counter checks follow WB_PERF_CNT_EN.
module tb_wb_stage;
`ifdef WB_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  bit   cmp_on;

  wb_stage_if #(.CNT_W(CNT_W)) wbi ();

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(input logic [2:0] code);
    return (code == 3'd0) || (code == 3'd1) || (code == 3'd2) || (code == 3'd4) || (code == 3'd5);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] code, input logic [31:0] addr,
                                         input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * addr[1:0])) & 32'h0000_00FF;
    h = (w >> (16 * addr[1])) & 32'h0000_FFFF;
    case (code)
      3'd0:    return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_en();
    return wbi.wbk_rd_reg_wb && (wbi.rd_adr_wb != 5'd0) && !wbi.rst_pipe_wb &&
           !(wbi.cmd_ld_wb && !m_legal(wbi.ld_code_wb));
  endfunction

  function automatic logic [31:0] m_data();
    return wbi.cmd_ld_wb ? m_load(wbi.ld_code_wb, wbi.rd_data_wb, wbi.ld_data_wb) : wbi.rd_data_wb;
  endfunction

  logic        m_en_h;
  logic [4:0]  m_adr_h;
  logic [31:0] m_data_h;
  logic        m_err;
  logic [31:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en_h   <= 1'b0;
      m_adr_h  <= 5'd0;
      m_data_h <= 32'd0;
      m_err    <= 1'b0;
      m_cnt    <= 32'd0;
    end else begin
      if (wbi.rst_pipe_wb) m_en_h <= 1'b0;
      else if (!wbi.stall || m_en()) begin
        m_en_h   <= m_en();
        m_adr_h  <= wbi.rd_adr_wb;
        m_data_h <= m_data();
      end
      m_err <= wbi.cmd_ld_wb && wbi.wbk_rd_reg_wb && !m_legal(wbi.ld_code_wb);
`ifdef WB_PERF_CNT_EN
      if (wbi.cnt_clr) m_cnt <= 32'd0;
      else if (m_en()) m_cnt <= (m_cnt + 32'd1) % (32'd1 << CNT_W);
`endif
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("wbk_en",      {31'd0, wbi.wbk_en},      {31'd0, m_en()});
      chk("wbk_adr",     {27'd0, wbi.wbk_adr},     {27'd0, wbi.rd_adr_wb});
      chk("wbk_data",    wbi.wbk_data,             m_data());
      chk("wbk_en_h",    {31'd0, wbi.wbk_en_h},    {31'd0, m_en_h});
      chk("wbk_adr_h",   {27'd0, wbi.wbk_adr_h},   {27'd0, m_adr_h});
      chk("wbk_data_h",  wbi.wbk_data_h,           m_data_h);
      chk("ld_code_err", {31'd0, wbi.ld_code_err}, {31'd0, m_err});
      chk("wr_cnt",      32'(wbi.wr_cnt),          m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic cmd, input logic [2:0] code, input logic [4:0] rd,
                     input logic [31:0] d, input logic wreg, input logic [31:0] ldw,
                     input logic stl, input logic fl, input logic clr);
    wbi.cmd_ld_wb     = cmd;
    wbi.ld_code_wb    = code;
    wbi.rd_adr_wb     = rd;
    wbi.rd_data_wb    = d;
    wbi.wbk_rd_reg_wb = wreg;
    wbi.ld_data_wb    = ldw;
    wbi.stall         = stl;
    wbi.rst_pipe_wb   = fl;
    wbi.cnt_clr       = clr;
    #2;
  endtask

  // advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] W = 32'h80FF_7F01;

  initial begin
    n_checks = 0;
    n_errors = 0;
    cmp_on   = 1'b0;
    rst_n    = 1'b0;
    drv(1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cmp_on = 1'b1;
    step();
    step();
    chk("rst_en_h",  {31'd0, wbi.wbk_en_h}, 32'd0);
    chk("rst_data_h", wbi.wbk_data_h,       32'd0);
    chk("rst_err",   {31'd0, wbi.ld_code_err}, 32'd0);
    chk("rst_cnt",   32'(wbi.wr_cnt),        32'd0);
    rst_n = 1'b1;
    step();

    // load extraction vectors
    drv(1'b1, 3'b000, 5'd5, 32'h0000_0103, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("lb_data", wbi.wbk_data, 32'hFFFF_FF80);
    chk("lb_en",   {31'd0, wbi.wbk_en}, 32'd1);
    step();
    drv(1'b1, 3'b101, 5'd5, 32'h0000_0102, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("lhu_data", wbi.wbk_data, 32'h0000_80FF);
    step();
    drv(1'b1, 3'b001, 5'd5, 32'h0000_0102, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("lh_data", wbi.wbk_data, 32'hFFFF_80FF);
    step();
    drv(1'b1, 3'b010, 5'd5, 32'h0000_0102, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("lw_data", wbi.wbk_data, 32'h80FF_7F01);
    step();
    drv(1'b1, 3'b100, 5'd6, 32'h0000_0101, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("lbu_data", wbi.wbk_data, 32'h0000_007F);
    step();
    drv(1'b1, 3'b001, 5'd6, 32'h0000_0103, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("lh_ofs3_data", wbi.wbk_data, 32'hFFFF_80FF);
    step();
    drv(1'b1, 3'b000, 5'd6, 32'h0000_0100, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("lb_ofs0_data", wbi.wbk_data, 32'h0000_0001);
    step();

    // x0 write suppressed, hold captures en=0
    drv(1'b0, 3'b000, 5'd0, 32'h0000_1234, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("x0_en", {31'd0, wbi.wbk_en}, 32'd0);
    step();
    chk("x0_en_h",   {31'd0, wbi.wbk_en_h}, 32'd0);
    chk("x0_data_h", wbi.wbk_data_h,        32'h0000_1234);

    // hold across stall, refreshed by a stall-finish write
    drv(1'b0, 3'b000, 5'd7, 32'h0000_00A5, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 3'b000, 5'd8, 32'h0000_0BAD, 1'b0, W, 1'b1, 1'b0, 1'b0);
      step();
      chk("stall_en_h",   {31'd0, wbi.wbk_en_h},  32'd1);
      chk("stall_adr_h",  {27'd0, wbi.wbk_adr_h}, 32'd7);
      chk("stall_data_h", wbi.wbk_data_h,         32'h0000_00A5);
    end
    drv(1'b0, 3'b000, 5'd9, 32'h0000_005A, 1'b1, W, 1'b1, 1'b0, 1'b0);
    step();
    chk("stwr_adr_h",  {27'd0, wbi.wbk_adr_h}, 32'd9);
    chk("stwr_data_h", wbi.wbk_data_h,         32'h0000_005A);

    // illegal load code
    drv(1'b1, 3'b011, 5'd4, 32'h0000_0100, 1'b1, W, 1'b0, 1'b0, 1'b0);
    chk("ill_en", {31'd0, wbi.wbk_en}, 32'd0);
    step();
    chk("ill_err1", {31'd0, wbi.ld_code_err}, 32'd1);
    drv(1'b1, 3'b010, 5'd4, 32'h0000_0100, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();
    chk("ill_err0", {31'd0, wbi.ld_code_err}, 32'd0);
    drv(1'b1, 3'b111, 5'd4, 32'h0000_0100, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();
    drv(1'b1, 3'b110, 5'd4, 32'h0000_0100, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();

    // flush (with and without stall) clears only the hold valid bit
    drv(1'b0, 3'b000, 5'd3, 32'h0000_0033, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();
    drv(1'b0, 3'b000, 5'd3, 32'h0000_0044, 1'b1, W, 1'b1, 1'b1, 1'b0);
    chk("flush_en", {31'd0, wbi.wbk_en}, 32'd0);
    step();
    chk("flush_en_h",   {31'd0, wbi.wbk_en_h}, 32'd0);
    chk("flush_data_h", wbi.wbk_data_h,        32'h0000_0033);
    drv(1'b0, 3'b000, 5'd2, 32'h0000_0055, 1'b1, W, 1'b0, 1'b1, 1'b0);
    step();

    // write-retire counter
    drv(1'b0, 3'b000, 5'd0, 32'd0, 1'b0, W, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 15; i++) begin
      drv(1'b0, 3'b000, 5'(i + 1), 32'(i), 1'b1, W, 1'b0, 1'b0, 1'b0);
      step();
    end
`ifdef WB_PERF_CNT_EN
    chk("cnt_15", 32'(wbi.wr_cnt), 32'd15);
`else
    chk("cnt_off", 32'(wbi.wr_cnt), 32'd0);
`endif
    drv(1'b0, 3'b000, 5'd1, 32'h0000_0016, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();
`ifdef WB_PERF_CNT_EN
    chk("cnt_wrap", 32'(wbi.wr_cnt), 32'd0);
`endif
    drv(1'b0, 3'b000, 5'd1, 32'h0000_0017, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();
    drv(1'b0, 3'b000, 5'd1, 32'h0000_0018, 1'b1, W, 1'b0, 1'b0, 1'b1);
    step();
    chk("cnt_clr_wr", 32'(wbi.wr_cnt), 32'd0);

    // asynchronous reset in mid-cycle
    drv(1'b0, 3'b000, 5'd12, 32'hDEAD_BEEF, 1'b1, W, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_en_h",   {31'd0, wbi.wbk_en_h},  32'd0);
    chk("arst_adr_h",  {27'd0, wbi.wbk_adr_h}, 32'd0);
    chk("arst_data_h", wbi.wbk_data_h,         32'd0);
    step();
    rst_n = 1'b1;
    drv(1'b0, 3'b000, 5'd0, 32'd0, 1'b0, W, 1'b0, 1'b0, 1'b0);
    step();
    step();
    cmp_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
